// File: rtl/fpga_status_pkg.sv
// Shared types for the FPGA status LED block.
//   led_mode_e : per-channel LED display mode (2 bits)
//   EXIT_WIDTH : width of the captured program exit code
package fpga_status_pkg;

    typedef enum logic [1:0] {
        LED_OFF       = 2'd0,
        LED_HEARTBEAT = 2'd1,
        LED_STRETCH   = 2'd2,
        LED_EXIT      = 2'd3
    } led_mode_e;

    localparam int unsigned EXIT_WIDTH = 32;

endpackage

// File: rtl/fpga_led_stretcher.sv
// Single-channel event pulse stretcher.
// A one-cycle event loads the counter with STRETCH_CYCLES; the counter then
// decrements to zero, so active_o stays high for exactly STRETCH_CYCLES
// cycles after an isolated event. A new event always reloads the counter,
// even on the cycle it would otherwise reach zero.
//   clk_gen  : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   event_i  : single-cycle event strobe
//   active_o : high while the stretch counter is nonzero
module fpga_led_stretcher
    import fpga_status_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = 2**20
) (
    input  logic clk_gen,
    input  logic rst_n,
    input  logic event_i,
    output logic active_o
);

    localparam int unsigned CW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (event_i) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign active_o = (cnt != '0);

endmodule

// File: rtl/fpga_status_leds.sv
// FPGA status LED driver.
// Each channel shows one of: off, a slow heartbeat, a stretched event pulse,
// or the program exit status (solid for exit code 0, fast blink otherwise).
// led_o is decoded only from registered state, so no input reaches it
// combinationally.
//   clk_gen        : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   mode_i         : per-channel mode, 2 bits per channel (led_mode_e)
//   event_i        : per-channel single-cycle event strobe
//   exit_valid_i   : program exit indication
//   exit_value_i   : program exit code
//   led_o          : LED drive, 1 = lit
//   exit_latched_o : sticky flag, exit code captured
//   exit_value_o   : captured exit code
module fpga_status_leds
    import fpga_status_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 4,
    parameter int unsigned CNT_WIDTH      = 27,
    parameter int unsigned STRETCH_CYCLES = 2**20
) (
    input  logic                    clk_gen,
    input  logic                    rst_n,
    input  logic [2*NUM_LEDS-1:0]   mode_i,
    input  logic [NUM_LEDS-1:0]     event_i,
    input  logic                    exit_valid_i,
    input  logic [EXIT_WIDTH-1:0]   exit_value_i,
    output logic [NUM_LEDS-1:0]     led_o,
    output logic                    exit_latched_o,
    output logic [EXIT_WIDTH-1:0]   exit_value_o
);

    logic [CNT_WIDTH-1:0] hb_cnt;
    led_mode_e            mode_q [NUM_LEDS];
    logic [NUM_LEDS-1:0]  stretch_active;
    logic                 exit_led;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= LED_OFF;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= led_mode_e'(mode_i[2*i +: 2]);
            end
        end
    end

    // First exit indication wins; later ones are ignored until reset.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            exit_latched_o <= 1'b0;
            exit_value_o   <= '0;
        end else if (exit_valid_i && !exit_latched_o) begin
            exit_latched_o <= 1'b1;
            exit_value_o   <= exit_value_i;
        end
    end

    // Stretchers run regardless of mode so a switch to LED_STRETCH
    // shows the in-flight stretch state.
    genvar g;
    generate
        for (g = 0; g < NUM_LEDS; g++) begin : g_stretch
            fpga_led_stretcher #(
                .STRETCH_CYCLES(STRETCH_CYCLES)
            ) u_stretch (
                .clk_gen (clk_gen),
                .rst_n   (rst_n),
                .event_i (event_i[g]),
                .active_o(stretch_active[g])
            );
        end
    endgenerate

    always_comb begin
        exit_led = 1'b0;
        if (exit_latched_o) begin
            exit_led = (exit_value_o == '0) ? 1'b1 : hb_cnt[CNT_WIDTH-3];
        end
    end

    always_comb begin
        led_o = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            unique case (mode_q[i])
                LED_OFF:       led_o[i] = 1'b0;
                LED_HEARTBEAT: led_o[i] = hb_cnt[CNT_WIDTH-1];
                LED_STRETCH:   led_o[i] = stretch_active[i];
                LED_EXIT:      led_o[i] = exit_led;
                default:       led_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_status_leds.sv
// Self-checking bench for fpga_status_leds (NUM_LEDS=4, CNT_WIDTH=4,
// STRETCH_CYCLES=3). Expected LED values are pushed to a queue as stimulus
// is driven and popped after the clock edge that should produce them.
module tb_fpga_status_leds;

    logic        clk_gen;
    logic        rst_n;
    logic [7:0]  mode_i;
    logic [3:0]  event_i;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic [3:0]  led_o;
    logic        exit_latched_o;
    logic [31:0] exit_value_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];

    fpga_status_leds #(
        .NUM_LEDS(4),
        .CNT_WIDTH(4),
        .STRETCH_CYCLES(3)
    ) dut (
        .clk_gen       (clk_gen),
        .rst_n         (rst_n),
        .mode_i        (mode_i),
        .event_i       (event_i),
        .exit_valid_i  (exit_valid_i),
        .exit_value_i  (exit_value_i),
        .led_o         (led_o),
        .exit_latched_o(exit_latched_o),
        .exit_value_o  (exit_value_o)
    );

    initial clk_gen = 1'b0;
    always #5 clk_gen = ~clk_gen;

    task automatic tick;
        @(posedge clk_gen);
        #1;
    endtask

    // Reset with the given mode already presented; returns between edges,
    // so the next tick is edge 1 after reset (hb_cnt == 1 afterwards).
    task automatic do_reset(input logic [7:0] m);
        rst_n        = 1'b0;
        event_i      = '0;
        exit_valid_i = 1'b0;
        exit_value_i = '0;
        mode_i       = m;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n        = 1'b0;
        mode_i       = 8'hFF;
        event_i      = 4'hF;
        exit_valid_i = 1'b1;
        exit_value_i = 32'h7;
        tick;
        tick;
        checks++;
        if (led_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_led: led_o=%b expected 0000", led_o);
        end
        checks++;
        if (exit_latched_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_latched: got %b expected 0", exit_latched_o);
        end
        checks++;
        if (exit_value_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_value: got %h expected 0", exit_value_o);
        end
        e = '{mask: 4'hF, exp: 4'h0};
        sb.push_back(e);
        do_reset(8'h00);
        e = sb.pop_front();
        checks++;
        if ((led_o & e.mask) !== e.exp) begin
            errors++;
            $display("FAIL reset_release: led_o=%b expected %b", led_o, e.exp);
        end
    endtask

    task automatic test_heartbeat;
        exp_t e;
        do_reset(8'h55);
        for (int k = 1; k <= 34; k++) begin
            e.mask = 4'hF;
            e.exp  = ((k % 16) >= 8) ? 4'hF : 4'h0;
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            checks++;
            if ((led_o & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL heartbeat edge %0d: led_o=%b expected %b", k, led_o, e.exp);
            end
        end
    endtask

    // Channel 0 in STRETCH; events at the listed edges (-1 = unused).
    task automatic test_stretch(input int ev0, input int ev1, input int ev2);
        exp_t e;
        logic lit;
        do_reset(8'h02);
        for (int k = 1; k <= 20; k++) begin
            event_i = (k == ev0 || k == ev1 || k == ev2) ? 4'b0001 : 4'b0000;
            lit = 1'b0;
            if (ev0 >= 0 && k >= ev0 && k < ev0 + 3) lit = 1'b1;
            if (ev1 >= 0 && k >= ev1 && k < ev1 + 3) lit = 1'b1;
            if (ev2 >= 0 && k >= ev2 && k < ev2 + 3) lit = 1'b1;
            e.mask = 4'hF;
            e.exp  = {3'b000, lit};
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            checks++;
            if ((led_o & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL stretch(%0d,%0d,%0d) edge %0d: led_o=%b expected %b",
                         ev0, ev1, ev2, k, led_o, e.exp);
            end
        end
        event_i = '0;
    endtask

    // Event while OFF, then switch to STRETCH mid-stretch.
    task automatic test_stretch_background;
        exp_t e;
        do_reset(8'h00);
        for (int k = 1; k <= 10; k++) begin
            event_i = (k == 5) ? 4'b0001 : 4'b0000;
            mode_i  = (k >= 6) ? 8'h02 : 8'h00;
            e.mask  = 4'hF;
            e.exp   = (k == 6 || k == 7) ? 4'b0001 : 4'b0000;
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            checks++;
            if ((led_o & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL stretch_bg edge %0d: led_o=%b expected %b", k, led_o, e.exp);
            end
        end
        event_i = '0;
    endtask

    task automatic test_exit_zero;
        exp_t e;
        do_reset(8'h0C);
        for (int k = 1; k <= 10; k++) begin
            exit_valid_i = (k == 4 || k == 6);
            exit_value_i = (k == 6) ? 32'h5 : 32'h0;
            e.mask = 4'b0010;
            e.exp  = (k >= 4) ? 4'b0010 : 4'b0000;
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            checks++;
            if ((led_o & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL exit_zero_led edge %0d: led_o=%b expected %b", k, led_o, e.exp);
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (exit_latched_o !== (k == 4)) begin
                    errors++;
                    $display("FAIL exit_zero_latch edge %0d: got %b expected %b",
                             k, exit_latched_o, (k == 4));
                end
            end
        end
        exit_valid_i = 1'b0;
        checks++;
        if (exit_value_o !== 32'h0) begin
            errors++;
            $display("FAIL exit_zero_value: got %h expected 00000000", exit_value_o);
        end
    endtask

    task automatic test_exit_blink;
        exp_t e;
        do_reset(8'h30);
        for (int k = 1; k <= 14; k++) begin
            exit_valid_i = (k == 3 || k == 8);
            exit_value_i = (k == 3) ? 32'h1 : 32'h0;
            e.mask = 4'b0100;
            e.exp  = (k >= 3 && (((k % 16) >> 1) & 1) == 1) ? 4'b0100 : 4'b0000;
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            checks++;
            if ((led_o & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL exit_blink edge %0d: led_o=%b expected %b", k, led_o, e.exp);
            end
        end
        exit_valid_i = 1'b0;
        checks++;
        if (exit_value_o !== 32'h1 || exit_latched_o !== 1'b1) begin
            errors++;
            $display("FAIL exit_blink_value: latched=%b value=%h expected 1 00000001",
                     exit_latched_o, exit_value_o);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(8'h0E);
        for (int k = 1; k <= 2; k++) begin
            event_i      = (k == 2) ? 4'b0001 : 4'b0000;
            exit_valid_i = (k == 2);
            exit_value_i = 32'hABCD_1234;
            tick;
        end
        event_i      = '0;
        exit_valid_i = 1'b0;
        checks++;
        if (led_o !== 4'b0011 || exit_value_o !== 32'hABCD_1234) begin
            errors++;
            $display("FAIL pre_reset: led_o=%b value=%h expected 0011 abcd1234",
                     led_o, exit_value_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_o !== 4'h0 || exit_latched_o !== 1'b0 || exit_value_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: led_o=%b latched=%b value=%h expected 0000 0 0",
                     led_o, exit_latched_o, exit_value_o);
        end
    endtask

    task automatic test_mode_latency;
        exp_t e;
        do_reset(8'h55);
        for (int k = 1; k <= 11; k++) begin
            if (k == 10) begin
                mode_i = 8'h00;
                #1;
                checks++;
                if (led_o !== 4'hF) begin
                    errors++;
                    $display("FAIL mode_comb_path: led_o=%b expected 1111", led_o);
                end
            end else if (k == 11) begin
                mode_i = 8'h55;
            end
            e.mask = 4'hF;
            e.exp  = (k == 10) ? 4'h0 : (((k % 16) >= 8) ? 4'hF : 4'h0);
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            checks++;
            if ((led_o & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL mode_latency edge %0d: led_o=%b expected %b", k, led_o, e.exp);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        mode_i       = '0;
        event_i      = '0;
        exit_valid_i = 1'b0;
        exit_value_i = '0;
        test_reset;
        test_heartbeat;
        test_stretch(10, -1, -1);
        test_stretch(10, 12, -1);
        test_stretch(10, 12, 15);
        test_stretch_background;
        test_exit_zero;
        test_exit_blink;
        test_reset_mid;
        test_mode_latency;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
